// File: rtl/control_fsm.sv
`default_nettype none
// ============================================================================
// control_fsm : multi-cycle instruction control FSM with fetch handshake,
//               datapath stalls, sticky illegal-instruction trap and retire count
// Revision    : 1.0
// ============================================================================
module control_fsm #(
  parameter int                 OPCODE_W   = 5,
  parameter int                 FUNC_W     = 4,
  parameter int                 ALUOP_W    = 4,
  parameter logic [ALUOP_W-1:0] ALUOP_PASS = 4'b1111,
  parameter int                 CNT_W      = 16
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                instr_valid,
  output logic                instr_ready,
  input  logic [OPCODE_W-1:0] opcode,
  input  logic [FUNC_W-1:0]   funct,
  input  logic                hold,
  output logic [ALUOP_W-1:0]  ALUop,
  output logic                regWrite,
  output logic                muxWriteReg,
  output logic                muxWriteData,
  output logic                irWrite,
  output logic                pcWrite,
  output logic                illegal,
  output logic                busy,
  output logic [CNT_W-1:0]    instr_count
);

  localparam logic [OPCODE_W-1:0] OP_AR     = OPCODE_W'(5'b00010);
  localparam logic [OPCODE_W-1:0] OP_T      = OPCODE_W'(5'b01011);
  localparam logic [FUNC_W-1:0]   FUNCT_MAX = FUNC_W'(4'b1000);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    WB     = 3'd3,
    TRAP   = 3'd4
  } state_t;

  state_t              state_q;
  state_t              state_d;
  logic [OPCODE_W-1:0] opcode_q;
  logic [FUNC_W-1:0]   funct_q;
  logic [ALUOP_W-1:0]  funct_alu;
  logic                is_ar;
  logic                is_t;
  logic                is_legal;

  // Only latched fields feed the decode, so opcode/funct never reach outputs.
  assign is_ar    = (opcode_q == OP_AR);
  assign is_t     = (opcode_q == OP_T);
  assign is_legal = is_t | (is_ar & (funct_q <= FUNCT_MAX));

  generate
    if (FUNC_W >= ALUOP_W) begin : g_funct_trunc
      assign funct_alu = funct_q[ALUOP_W-1:0];
    end else begin : g_funct_ext
      assign funct_alu = {{(ALUOP_W-FUNC_W){1'b0}}, funct_q};
    end
  endgenerate

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q     <= FETCH;
      opcode_q    <= '0;
      funct_q     <= '0;
      instr_count <= '0;
    end else begin
      state_q <= state_d;
      if (irWrite) begin
        opcode_q <= opcode;
        funct_q  <= funct;
      end
      if (regWrite) begin
        instr_count <= instr_count + CNT_W'(1);
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    instr_ready  = 1'b0;
    irWrite      = 1'b0;
    regWrite     = 1'b0;
    pcWrite      = 1'b0;
    ALUop        = ALUOP_PASS;
    muxWriteReg  = 1'b0;
    muxWriteData = 1'b0;
    busy         = 1'b0;
    illegal      = 1'b0;

    case (state_q)
      FETCH: begin
        instr_ready = 1'b1;
        if (instr_valid) begin
          irWrite = 1'b1;
          state_d = DECODE;
        end
      end
      DECODE: begin
        busy    = 1'b1;
        state_d = is_legal ? EXEC : TRAP;
      end
      EXEC, WB: begin
        busy = 1'b1;
        // Only AR and T ever reach EXEC/WB; anything else trapped in DECODE.
        if (is_t) begin
          muxWriteReg  = 1'b1;
          muxWriteData = 1'b1;
        end else begin
          ALUop = funct_alu;
        end
        if (!hold) begin
          if (state_q == WB) begin
            regWrite = 1'b1;
            pcWrite  = 1'b1;
            state_d  = FETCH;
          end else begin
            state_d = WB;
          end
        end
      end
      TRAP: begin
        illegal = 1'b1;
      end
      default: begin
        state_d = FETCH;
      end
    endcase
  end

endmodule
`default_nettype wire
